// File: rtl/regfile_wb_unit.sv
// 32 x XLEN register file with writeback port, 1-cycle registered reads and a pending-write scoreboard.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            wr_en_in,
  input  logic [4:0]      rd_addr_in,
  input  logic [XLEN-1:0] wb_data_in,
  input  logic [4:0]      rs1_addr_in,
  input  logic [4:0]      rs2_addr_in,
  input  logic            issue_en_in,
  input  logic [4:0]      issue_rd_in,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out,
  output logic            hazard_out,
  output logic [31:0]     pending_out
);

  logic [XLEN-1:0] regs [32];
  logic [31:0]     pending_q;
  logic [31:0]     pending_next;
  logic            wb_hit;
  logic            issue_hit;
  logic            rs1_byp;
  logic            rs2_byp;
  logic [XLEN-1:0] rs1_next;
  logic [XLEN-1:0] rs2_next;

  assign wb_hit    = wr_en_in && (rd_addr_in != 5'd0);
  assign issue_hit = issue_en_in && (issue_rd_in != 5'd0);

`ifdef REGFILE_WB_BYPASS_EN
  assign rs1_byp  = wb_hit && (rd_addr_in == rs1_addr_in);
  assign rs2_byp  = wb_hit && (rd_addr_in == rs2_addr_in);
  assign rs1_next = rs1_byp ? wb_data_in : regs[rs1_addr_in];
  assign rs2_next = rs2_byp ? wb_data_in : regs[rs2_addr_in];
`else
  assign rs1_byp  = 1'b0;
  assign rs2_byp  = 1'b0;
  assign rs1_next = regs[rs1_addr_in];
  assign rs2_next = regs[rs2_addr_in];
`endif

  // regs[0] is cleared at reset and never written, so x0 always reads zero.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[rd_addr_in] <= wb_data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rs1_out <= '0;
      rs2_out <= '0;
    end else begin
      rs1_out <= rs1_next;
      rs2_out <= rs2_next;
    end
  end

  // Set wins over clear so a new producer issued alongside the old writeback stays tracked.
  always_comb begin
    pending_next = pending_q;
    if (wb_hit) begin
      pending_next[rd_addr_in] = 1'b0;
    end
    if (issue_hit) begin
      pending_next[issue_rd_in] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_next;
    end
  end

  assign hazard_out  = (pending_q[rs1_addr_in] && !rs1_byp) ||
                       (pending_q[rs2_addr_in] && !rs2_byp);
  assign pending_out = pending_q;

endmodule

// File: tb/tb_regfile_wb_unit.sv
// Scoreboard bench for regfile_wb_unit: stimulus pushes expectations tagged with the cycle they
// apply to; a negedge monitor pops and compares them. Honours REGFILE_WB_BYPASS_EN like the RTL.
module tb_regfile_wb_unit;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        wr_en_in = 1'b0;
  logic [4:0]  rd_addr_in = '0;
  logic [31:0] wb_data_in = '0;
  logic [4:0]  rs1_addr_in = '0;
  logic [4:0]  rs2_addr_in = '0;
  logic        issue_en_in = 1'b0;
  logic [4:0]  issue_rd_in = '0;
  logic [31:0] rs1_out;
  logic [31:0] rs2_out;
  logic        hazard_out;
  logic [31:0] pending_out;

  typedef struct packed {
    int          cyc;
    logic        chk_rd;
    logic        chk_pend;
    logic        chk_haz;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pend;
    logic        haz;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  bit    byp;

  regfile_wb_unit #(.XLEN(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr_en_in(wr_en_in), .rd_addr_in(rd_addr_in),
    .wb_data_in(wb_data_in), .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
    .issue_en_in(issue_en_in), .issue_rd_in(issue_rd_in), .rs1_out(rs1_out),
    .rs2_out(rs2_out), .hazard_out(hazard_out), .pending_out(pending_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic applyStimulus(input logic rst, input logic wr, input logic [4:0] rd,
                               input logic [31:0] data, input logic [4:0] a1, input logic [4:0] a2,
                               input logic iss, input logic [4:0] ird);
    rst_in = rst; wr_en_in = wr; rd_addr_in = rd; wb_data_in = data;
    rs1_addr_in = a1; rs2_addr_in = a2; issue_en_in = iss; issue_rd_in = ird;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Read data and scoreboard state land one edge later; hazard is checked in the current cycle.
  task automatic expRead(input string nm, input logic [31:0] a, input logic [31:0] b);
    exp_t e = '0;
    e.cyc = cyc + 1; e.chk_rd = 1'b1; e.rs1 = a; e.rs2 = b;
    exp_q.push_back(e); name_q.push_back(nm);
  endtask

  task automatic expPend(input string nm, input logic [31:0] p);
    exp_t e = '0;
    e.cyc = cyc + 1; e.chk_pend = 1'b1; e.pend = p;
    exp_q.push_back(e); name_q.push_back(nm);
  endtask

  task automatic expHaz(input string nm, input logic h);
    exp_t e = '0;
    e.cyc = cyc; e.chk_haz = 1'b1; e.haz = h;
    exp_q.push_back(e); name_q.push_back(nm);
  endtask

  task automatic checkOutput(input exp_t e, input string nm);
    if (e.chk_rd) begin
      tests++;
      if (rs1_out !== e.rs1 || rs2_out !== e.rs2) begin
        fails++;
        $display("[TB] FAIL %s: rs1=%h rs2=%h, expected rs1=%h rs2=%h", nm, rs1_out, rs2_out, e.rs1, e.rs2);
      end
    end
    if (e.chk_pend) begin
      tests++;
      if (pending_out !== e.pend) begin
        fails++;
        $display("[TB] FAIL %s: pending=%h, expected %h", nm, pending_out, e.pend);
      end
    end
    if (e.chk_haz) begin
      tests++;
      if (hazard_out !== e.haz) begin
        fails++;
        $display("[TB] FAIL %s: hazard=%b, expected %b", nm, hazard_out, e.haz);
      end
    end
  endtask

  always @(negedge clk_in) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        checkOutput(exp_q[i], name_q[i]);
        exp_q.delete(i);
        name_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        tests++;
        fails++;
        $display("[TB] FAIL %s: check missed at cycle %0d, expected cycle %0d", name_q[i], cyc, exp_q[i].cyc);
        exp_q.delete(i);
        name_q.delete(i);
      end
    end
  end

  initial begin
`ifdef REGFILE_WB_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    step();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    expRead("reset_rd", 32'h0, 32'h0);
    expPend("reset_pend", 32'h0);
    step();

    applyStimulus(0, 1, 5, 32'h12345678, 0, 0, 0, 0);
    expHaz("idle_haz", 1'b0);
    step();
    applyStimulus(0, 0, 0, 0, 5, 0, 0, 0);
    expRead("read_x5", 32'h12345678, 32'h0);
    step();

    applyStimulus(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    expRead("x0_write_same", 32'h0, 32'h0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    expRead("x0_read", 32'h0, 32'h0);
    expPend("x0_pend", 32'h0);
    step();

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
    expHaz("issue7_haz_none", 1'b0);
    expPend("issue7_pend", 32'h00000080);
    step();
    applyStimulus(0, 0, 0, 0, 0, 7, 0, 0);
    expHaz("x7_hazard", 1'b1);
    step();
    applyStimulus(0, 1, 7, 32'hA5A5A5A5, 0, 7, 0, 0);
    expHaz("x7_wb_haz", byp ? 1'b0 : 1'b1);
    expRead("x7_wb_read", 32'h0, byp ? 32'hA5A5A5A5 : 32'h0);
    expPend("x7_wb_pend", 32'h0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 7, 0, 0);
    expHaz("x7_clear_haz", 1'b0);
    expRead("x7_read", 32'h0, 32'hA5A5A5A5);
    step();

    applyStimulus(0, 1, 3, 32'h11, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
    expPend("issue3_pend", 32'h00000008);
    step();
    applyStimulus(0, 1, 3, 32'h55, 3, 0, 0, 0);
    expHaz("x3_same_haz", byp ? 1'b0 : 1'b1);
    expRead("x3_same_read", byp ? 32'h55 : 32'h11, 32'h0);
    expPend("x3_wb_pend", 32'h0);
    step();
    applyStimulus(0, 0, 0, 0, 3, 0, 0, 0);
    expRead("x3_read", 32'h55, 32'h0);
    step();

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
    expPend("issue9_pend", 32'h00000200);
    step();
    applyStimulus(0, 1, 9, 32'h99, 0, 0, 1, 9);
    expPend("set_clear_same", 32'h00000200);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 6);
    expPend("issue6_pend", 32'h00000240);
    step();
    applyStimulus(0, 1, 6, 32'h66, 0, 0, 1, 4);
    expPend("set_clear_diff", 32'h00000210);
    step();
    applyStimulus(0, 0, 0, 0, 9, 4, 1, 4);
    expHaz("x9_x4_haz", 1'b1);
    expRead("x9_x4_read", 32'h99, 32'h0);
    expPend("reissue4_pend", 32'h00000210);
    step();
    applyStimulus(0, 0, 0, 0, 6, 0, 1, 0);
    expHaz("x6_haz_clear", 1'b0);
    expRead("x6_read", 32'h66, 32'h0);
    expPend("issue0_ignored", 32'h00000210);
    step();

    applyStimulus(0, 1, 10, 32'h1, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 12);
    expPend("issue12_pend", 32'h00001210);
    step();
    applyStimulus(1, 1, 11, 32'h77, 10, 11, 1, 13);
    expRead("rst_dominates_rd", 32'h0, 32'h0);
    expPend("rst_dominates_pend", 32'h0);
    step();
    applyStimulus(0, 0, 0, 0, 10, 11, 0, 0);
    expHaz("post_rst_haz", 1'b0);
    expRead("post_rst_x10_x11", 32'h0, 32'h0);
    step();
    applyStimulus(0, 1, 11, 32'h33, 9, 4, 1, 2);
    expHaz("post_rst_haz2", 1'b0);
    expRead("post_rst_x9_x4", 32'h0, 32'h0);
    expPend("post_rst_issue2", 32'h00000004);
    step();
    applyStimulus(0, 0, 0, 0, 11, 2, 0, 0);
    expHaz("post_rst_x2_haz", 1'b1);
    expRead("post_rst_x11", 32'h33, 32'h0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();

    if (exp_q.size() != 0) begin
      fails += exp_q.size();
      tests += exp_q.size();
      $display("[TB] FAIL leftover: %0d unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_unit.md
REGFILE_WB_UNIT -- requirements
Module: regfile_wb_unit

Interface
REQ-001 Parameter XLEN, default 32, data width of every register and data port.
REQ-002 clk_in  input  1  rising-edge clock, sole clock.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 wr_en_in  input  1  writeback strobe, driven by the pipeline alongside the writeback mux output.
REQ-005 rd_addr_in  input  5  writeback destination register index.
REQ-006 wb_data_in  input  XLEN  writeback data (writeback mux output).
REQ-007 rs1_addr_in  input  5  read port 1 index.
REQ-008 rs2_addr_in  input  5  read port 2 index.
REQ-009 issue_en_in  input  1  instruction with a destination register issued this cycle.
REQ-010 issue_rd_in  input  5  destination index of the issued instruction.
REQ-011 rs1_out  output  XLEN  registered read data, port 1.
REQ-012 rs2_out  output  XLEN  registered read data, port 2.
REQ-013 hazard_out  output  1  combinational: a source operand awaits a pending writeback.
REQ-014 pending_out  output  32  scoreboard vector, bit i = register i pending.

Function
REQ-015 Register file SHALL hold 32 x XLEN registers; x0 SHALL always read 0 and SHALL ignore writes.
REQ-016 Write: on rising edge with wr_en_in=1 and rd_addr_in!=0, reg[rd_addr_in] SHALL take wb_data_in; wr_en_in=0 SHALL leave all registers unchanged.
REQ-017 Read latency SHALL be exactly 1 cycle: rs1_out/rs2_out after edge N SHALL reflect rs1_addr_in/rs2_addr_in sampled at edge N.
REQ-018 Same-cycle write and read of the same nonzero index SHALL follow REQ-031/REQ-032.
REQ-019 Scoreboard: issue_en_in=1 with issue_rd_in!=0 SHALL set pending[issue_rd_in] at the edge.
REQ-020 wr_en_in=1 with rd_addr_in!=0 SHALL clear pending[rd_addr_in] at the edge.
REQ-021 Simultaneous set and clear of the same index SHALL leave the bit set (new producer in flight).
REQ-022 Simultaneous set and clear of different indices SHALL both take effect.
REQ-023 pending[0] SHALL be constant 0; issue_rd_in=0 SHALL be ignored.
REQ-024 Issuing an already-pending index SHALL keep it set (no counting; one outstanding producer per register).
REQ-025 hazard_out SHALL be 1 iff pending[rs1_addr_in] or pending[rs2_addr_in] is 1, minus the bypass exemption of REQ-031.
REQ-026 pending_out SHALL equal the scoreboard register state.

Reset
REQ-027 rst_in=1 at an edge SHALL clear all 31 writable registers, rs1_out, rs2_out, pending_out to 0.
REQ-028 Reset SHALL dominate wr_en_in and issue_en_in asserted in the same cycle; neither takes effect.
REQ-029 Reset mid-operation SHALL discard all pending state; the first edge after deassertion behaves as normal operation.
REQ-030 hazard_out SHALL be 0 while pending state is 0 after reset.

Configuration
REQ-031 With macro REGFILE_WB_BYPASS_EN defined: when wr_en_in=1, rd_addr_in!=0 and rd_addr_in equals a read index, that port's output SHALL take wb_data_in at the edge; that operand SHALL NOT contribute to hazard_out in that cycle.
REQ-032 Without REGFILE_WB_BYPASS_EN: same-cycle read SHALL return the pre-write value; hazard_out SHALL follow the pending bit only.

Verification
REQ-033 Reset, then write x5=0x12345678, next cycle read rs1=5 -> rs1_out=0x12345678 one cycle later.
REQ-034 Write x0=0xFFFFFFFF, read rs1=0, rs2=0 -> both outputs 0; pending_out=0.
REQ-035 Issue rd=7; next cycle rs2_addr=7 -> hazard_out=1, pending_out=0x00000080; writeback x7=0xA5A5A5A5 -> pending clears, hazard_out=0.
REQ-036 Same cycle wr x3=0x55 and read rs1=3 (x3 previously 0x11) -> rs1_out=0x55 with REGFILE_WB_BYPASS_EN, 0x11 without; hazard_out=0 with macro, 1 without, if x3 pending.
REQ-037 Same cycle issue rd=9 and writeback rd=9 -> pending bit 9 stays 1; issue rd=4 with writeback rd=6 (pending) -> bit 4 set, bit 6 cleared.
REQ-038 Write x10=0x1, issue rd=12, then rst_in=1 together with wr x11 and issue rd=13 -> all outputs 0, x10/x11 read 0, pending_out=0.
